// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule types, PC-1/PC-2 tables, shift schedule and half rotation
package des_pkg;

    typedef logic [27:0] des_half_t;
    typedef logic [47:0] des_subkey_t;

    typedef enum logic {
        PERM_PC1 = 1'b0,
        PERM_PC2 = 1'b1
    } perm_sel_e;

    localparam logic [1:0] SHIFT_SCHED [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Source bit numbers are DES 1-based, MSB first.
    localparam int PC1_IDX [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_IDX [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // A left rotation by n is done as a right rotation by 28-n of the doubled word.
    function automatic des_half_t rot_half(input des_half_t half,
                                           input logic [1:0] amount,
                                           input logic       dir_right);
        logic [55:0] dbl;
        logic [5:0]  sh;
        sh  = dir_right ? {4'd0, amount} : (6'd28 - {4'd0, amount});
        dbl = {half, half} >> sh;
        return dbl[27:0];
    endfunction

endpackage

// File: rtl/des_key_perm.sv
// rtl/des_key_perm.sv - combinational DES PC-1 / PC-2 bit selection
module des_key_perm
    import des_pkg::*;
#(
    parameter int OUT_W = 56
) (
    input  logic [63:0]      din,
    input  perm_sel_e        sel,
    output logic [OUT_W-1:0] dout
);

    // PC-2 reads the 56-bit C||D word held in din[55:0].
    always_comb begin
        dout = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (sel == PERM_PC1) begin
                dout[OUT_W-1-i] = din[64-PC1_IDX[i]];
            end else if (i < 48) begin
                dout[OUT_W-1-i] = din[56-PC2_IDX[i]];
            end
        end
    end

endmodule

// File: rtl/des_key_sched_rev.sv
// rtl/des_key_sched_rev.sv - iterative DES subkey generator, K16..K1 order; DES_KS_BIDIR_EN adds K1..K16
module des_key_sched_rev
    import des_pkg::*;
#(
    parameter int KEY_W  = 64,
    parameter int HALF_W = 28,
    parameter int SK_W   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [SK_W-1:0]  subkey,
    output logic [3:0]       sk_round,
    output logic             sk_last,
    output logic             sk_valid,
    input  logic             sk_ready
`ifdef DES_KS_BIDIR_EN
   ,input  logic             mode_enc
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                key_ready_q, key_ready_d;
    logic                sk_valid_q, sk_valid_d;
    logic                enc_q, enc_d;
    logic [55:0]         pc1_out;
    logic [SK_W-1:0]     pc2_out;
    logic [4:0]          sh_idx;
    logic                fire;

    des_key_perm #(.OUT_W(56)) u_pc1 (
        .din  (key_in),
        .sel  (PERM_PC1),
        .dout (pc1_out)
    );

    des_key_perm #(.OUT_W(SK_W)) u_pc2 (
        .din  ({8'd0, c_q, d_q}),
        .sel  (PERM_PC2),
        .dout (pc2_out)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
`ifdef DES_KS_BIDIR_EN
        enc_d   = (state_q == ST_IDLE && key_valid) ? mode_enc : enc_q;
`else
        enc_d   = 1'b0;
`endif
        fire    = sk_valid_q && sk_ready;
        // Decrypt walks SHIFT backwards from 16, encrypt forwards from 2.
        sh_idx  = enc_q ? ({1'b0, cnt_q} + 5'd2) : (5'd16 - {1'b0, cnt_q});

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_ISSUE;
                    cnt_d   = 4'd0;
                    if (enc_d) begin
                        c_d = rot_half(pc1_out[55:28], SHIFT_SCHED[1], 1'b0);
                        d_d = rot_half(pc1_out[27:0],  SHIFT_SCHED[1], 1'b0);
                    end else begin
                        c_d = pc1_out[55:28];
                        d_d = pc1_out[27:0];
                    end
                end
            end
            ST_ISSUE: begin
                if (fire) begin
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        c_d   = rot_half(c_q, SHIFT_SCHED[sh_idx], !enc_q);
                        d_d   = rot_half(d_q, SHIFT_SCHED[sh_idx], !enc_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        key_ready_d = (state_d == ST_IDLE);
        sk_valid_d  = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= 4'd0;
            enc_q       <= 1'b0;
            key_ready_q <= 1'b1;
            sk_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            enc_q       <= enc_d;
            key_ready_q <= key_ready_d;
            sk_valid_q  <= sk_valid_d;
        end
    end

    assign key_ready = key_ready_q;
    assign sk_valid  = sk_valid_q;
    assign subkey    = pc2_out;
    assign sk_round  = cnt_q;
    assign sk_last   = sk_valid_q && (cnt_q == 4'd15);

endmodule

// File: doc/des_key_sched_rev.md
Name: des_key_sched_rev

Overview:
- Iterative DES key-schedule generator for the decryption direction.
- Accepts one 64-bit key and streams the 16 round subkeys in reverse order: K16 first, then K15 down to K1.
- Each subkey is issued on a valid/ready output; one subkey per cycle when not back-pressured.
- Feeds the decrypt round datapath; pairs with the existing forward permutation logic (PC-1/PC-2 tables).

Parameters:
- KEY_W, 64, input key width (fixed by DES; not overridable in practice)
- HALF_W, 28, width of C and D key halves
- SK_W, 48, subkey width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- key_in  input  64  DES key; DES bit i (1 = MSB) is key_in[64-i]; parity bits are ignored
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a key
- subkey  output  48  current subkey; DES bit j (1 = MSB) is subkey[48-j]
- sk_round  output  4  decryption round index minus 1 (0..15); 0 means K16, 15 means K1
- sk_last  output  1  high with the final subkey (K1)
- sk_valid  output  1  subkey is valid
- sk_ready  input  1  consumer accepts the subkey

Behaviour:
- Reset (async assert, sync release): state=IDLE, C=D=0, round counter=0, subkey=0, sk_round=0, sk_valid=0, sk_last=0, key_ready=1.
- States:
  - IDLE: key_ready=1, sk_valid=0. On key_valid && key_ready, load C||D = PC-1(key_in) and counter=0, then go to ISSUE. No rotation is applied, because C16=C0 and D16=D0.
  - ISSUE: key_ready=0, sk_valid=1, subkey = PC-2(C||D), sk_round = counter, sk_last = (counter==15).
- Latency: key accepted at edge T gives K16 valid immediately after T, i.e. first sk_valid in cycle T+1.
- On an sk_valid && sk_ready edge in ISSUE:
  - If counter < 15: counter += 1. C and D each rotate RIGHT by SHIFT[16-counter_old], where SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - If counter == 15: go to IDLE; key_ready=1 in the next cycle. C and D are left as-is; their contents are don't-care.
- Back-pressure: while sk_valid && !sk_ready, subkey, sk_round and sk_last are held stable and no rotation occurs.
- Full sequence: 16 handshakes; with sk_ready tied high, 17 cycles from key acceptance to the next key_ready.
- No new key is accepted mid-sequence; key_valid is ignored outside IDLE.
- subkey, sk_round and sk_last are driven combinationally from registered C, D and counter. There is no combinational path from any input to any output.
- Reset mid-sequence: everything returns to reset values immediately; any partial sequence is discarded.
- Rotation is modulo 28 within each half independently.

Optional Feature:
- Macro: DES_KS_BIDIR_EN.
- With the macro: adds input mode_enc (1 bit), sampled at key acceptance and held for the whole sequence.
  - mode_enc=1 (encrypt order): load C||D = rotl(PC-1(key), SHIFT[1]) and issue K1..K16.
  - After each handshake with counter < 15, rotate LEFT by SHIFT[counter_old+2].
  - sk_round 0 means K1; sk_last is high with K16.
  - mode_enc=0 behaves exactly as the base block.
- Without the macro: the port is absent and only decrypt order exists.

Decomposition:
- Package des_pkg holds:
  - typedefs des_half_t [27:0] and des_subkey_t [47:0]
  - constant SHIFT_SCHED[1..16]
  - constant tables PC1_IDX[56] and PC2_IDX[48], using DES 1-based numbering
  - function rot_half(half, amount, dir)
- One combinational sub-module, des_key_perm, selects PC-1 or PC-2 by an input select. It is instantiated twice:
  - PC-1 on key_in
  - PC-2 on C||D

Test Plan:
- Key 0x133457799BBCDFF1, sk_ready=1 -> sk_round 0: 0xCB3D8B0E17F5 (K16); round 1: 0xBF918D3D3F0A (K15); round 14: 0x79AED9DBC9E5 (K2); round 15: 0x1B02EFFC7072 (K1) with sk_last=1. key_ready returns 17 cycles after acceptance.
- Same key, sk_ready toggled 1,0,0,1 pseudo-randomly -> identical subkey sequence. Outputs remain stable during every stall; exactly 16 handshakes occur.
- Key 0x0000000000000000 -> all 16 subkeys 0. Key 0xFFFFFFFFFFFFFFFF -> all 16 subkeys 0xFFFFFFFFFFFF.
- key_valid held high during ISSUE with a different key_in -> ignored; sequence completes for the original key. The second key is accepted only at the next IDLE.
- rst_n pulsed low after the 5th handshake -> immediately sk_valid=0, key_ready=1, subkey=0. A fresh key after release restarts from K16.
- With DES_KS_BIDIR_EN and mode_enc=1, key 0x133457799BBCDFF1 -> first subkey 0x1B02EFFC7072, second 0x79AED9DBC9E5, last 0xCB3D8B0E17F5.
